clk_en_gen: RTL and testbench

Parametrised, runtime-programmable clock-enable generator for the core's single system clock. It replaces fixed-frequency PLL outputs for slow core domains (CPU, sound, pixel) with NUM_CH fractional phase accumulators. Each channel emits one-cycle rising-phase (ce_p) and falling-phase (ce_n) enables. A lock handshake phase-aligns all channels after reset or reprogramming.

---
 rtl/clk_en_pkg.sv | 28 ++
 rtl/clk_en_acc.sv | 67 ++++++
 rtl/clk_en_gen.sv | 93 +++++++++
 tb/tb_clk_en_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_pkg
// Description : Shared types and helpers for the clock-enable generator.
// Revision    : 1.0 - initial release
// ============================================================================

package clk_en_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Increment for a target rate: round(f_out * 2^acc_w / f_clk).
    function automatic logic [63:0] inc_for(
        input logic [63:0] f_clk_hz,
        input logic [63:0] f_out_hz,
        input int unsigned acc_w
    );
        logic [63:0] num;
        num = (f_out_hz << acc_w) + (f_clk_hz >> 1);
        return num / f_clk_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_en_acc.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_acc
// Description : One fractional phase-accumulator channel with registered
//               rising/falling phase enables.
// Revision    : 1.0 - initial release
// ============================================================================

module clk_en_acc
    import clk_en_pkg::*;
#(
    parameter int unsigned      ACC_W   = 24,
    parameter logic [ACC_W-1:0] RST_INC = '0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             ce_p,
    output logic             ce_n
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             ce_p_q, ce_p_d;
    logic             ce_n_q, ce_n_d;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
        acc_d  = acc_q;
        inc_d  = wr_en ? wr_inc : inc_q;
        ce_p_d = 1'b0;
        ce_n_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            acc_d  = w_sum[ACC_W-1:0];
            ce_p_d = w_sum[ACC_W];
            // Half-phase crossing without wrap marks the falling phase
            ce_n_d = !acc_q[ACC_W-1] & w_sum[ACC_W-1] & !w_sum[ACC_W];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q  <= '0;
            inc_q  <= RST_INC;
            ce_p_q <= 1'b0;
            ce_n_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            ce_p_q <= ce_p_d;
            ce_n_q <= ce_n_d;
        end
    end

    assign ce_p = ce_p_q;
    assign ce_n = ce_n_q;

endmodule

`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_gen
// Description : Runtime-programmable multi-channel clock-enable generator with
//               a settle/lock handshake that phase-aligns all channels.
// Revision    : 1.0 - initial release
// ============================================================================

module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int unsigned               NUM_CH      = 4,
    parameter int unsigned               ACC_W       = 24,
    parameter int unsigned               LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0]   DEF_INC     = {NUM_CH{24'h100000}},
    localparam int unsigned              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              pause,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [ACC_W-1:0]  wr_inc,
    output logic [NUM_CH-1:0] ce_p,
    output logic [NUM_CH-1:0] ce_n,
    output logic              locked
);

    localparam int unsigned      CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              w_wr_valid;
    logic [NUM_CH-1:0] w_wr_sel;
    logic [NUM_CH-1:0] w_clear;
    logic [NUM_CH-1:0] w_advance;

    assign w_wr_valid = wr && (32'(wr_ch) < NUM_CH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (w_wr_valid) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = LOCKED;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked = (state_q == LOCKED);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr_sel[g]  = w_wr_valid && (32'(wr_ch) == 32'(g));
        // A write restarts alignment, so it outranks pause; pause outranks ch_en
        assign w_clear[g]   = (state_q == SETTLE) || w_wr_valid || (!pause && !ch_en[g]);
        assign w_advance[g] = (state_q == LOCKED) && !w_wr_valid && !pause && ch_en[g];

        clk_en_acc #(
            .ACC_W   (ACC_W),
            .RST_INC (DEF_INC[g*ACC_W +: ACC_W])
        ) u_acc (
            .clk_sys (clk_sys),
            .reset   (reset),
            .clear   (w_clear[g]),
            .advance (w_advance[g]),
            .wr_en   (w_wr_sel[g]),
            .wr_inc  (wr_inc),
            .ce_p    (ce_p[g]),
            .ce_n    (ce_n[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_en_gen
// Description : Self-checking bench for clk_en_gen; expected pulse events are
//               queued as stimulus is applied and matched against the outputs.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_clk_en_gen;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 24;
    localparam int LOCK   = 16;
    localparam int HIST   = 2048;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              pause;
    logic [NUM_CH-1:0] ch_en;
    logic              wr;
    logic [1:0]        wr_ch;
    logic [ACC_W-1:0]  wr_inc;
    logic [NUM_CH-1:0] ce_p;
    logic [NUM_CH-1:0] ce_n;
    logic              locked;

    int cyc;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int obs_q[$];
    logic [NUM_CH-1:0] cp_hist [HIST];
    logic [NUM_CH-1:0] cn_hist [HIST];
    logic              lk_hist [HIST];

    clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK),
        .DEF_INC     ({NUM_CH{24'h100000}})
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pause   (pause),
        .ch_en   (ch_en),
        .wr      (wr),
        .wr_ch   (wr_ch),
        .wr_inc  (wr_inc),
        .ce_p    (ce_p),
        .ce_n    (ce_n),
        .locked  (locked)
    );

    always #5 clk_sys = ~clk_sys;

    // Event code: cycle*64 + channel*2 + (1 for ce_n, 0 for ce_p)
    task automatic collect(input int n, input logic [NUM_CH-1:0] mask);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (cyc >= 0 && cyc < HIST) begin
                cp_hist[cyc] = ce_p;
                cn_hist[cyc] = ce_n;
                lk_hist[cyc] = locked;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (mask[ch] && ce_p[ch] === 1'b1) obs_q.push_back(cyc*64 + ch*2);
                if (mask[ch] && ce_n[ch] === 1'b1) obs_q.push_back(cyc*64 + ch*2 + 1);
            end
        end
    endtask

    task automatic test_reset();
        int rise;
        reset = 1'b1; pause = 1'b0; wr = 1'b0; wr_ch = '0; wr_inc = '0; ch_en = '1;
        collect(3, '0);
        reset = 1'b0;
        cyc = 0;
        obs_q.delete();
        exp_q.delete();
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b expected 0", locked); end
        n_cmp++; if (ce_p !== '0) begin n_bad++; $display("FAIL reset_ce_p got %b expected 0000", ce_p); end
        n_cmp++; if (ce_n !== '0) begin n_bad++; $display("FAIL reset_ce_n got %b expected 0000", ce_n); end
        rise = -1;
        for (int i = 0; i < 40 && rise < 0; i++) begin
            collect(1, '1);
            if (locked === 1'b1) rise = cyc;
        end
        n_cmp++; if (rise != LOCK) begin n_bad++; $display("FAIL reset_lock_rise got cycle %0d expected %0d", rise, LOCK); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_quiet got %0d pulses expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_default_rate();
        int e, o;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int t = LOCK + 8; t + 8 <= 80; t += 16) begin
                exp_q.push_back(t*64 + ch*2 + 1);
                exp_q.push_back((t + 8)*64 + ch*2);
            end
        exp_q.sort();
        collect(80 - cyc, '1);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL default_ev got cyc %0d ch %0d n %0d expected cyc %0d ch %0d n %0d", o/64, (o%64)/2, o%2, e/64, (e%64)/2, e%2);
            end
        end
    endtask

    task automatic test_write_relock();
        int e, o, first_p, first_n, np, nn, lk_hi, quiet, bad_win, bad_rep, w;
        wr = 1'b1; wr_ch = 2'd1; wr_inc = 24'h600000;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ch == 1) continue;
            for (int t = 97 + 8; t <= 897; t += 16) begin
                exp_q.push_back(t*64 + ch*2 + 1);
                if (t + 8 <= 897) exp_q.push_back((t + 8)*64 + ch*2);
            end
        end
        exp_q.sort();
        collect(1, 4'b1101);
        wr = 1'b0; wr_inc = '0;
        collect(897 - cyc, 4'b1101);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL relock_ev got cyc %0d ch %0d n %0d expected cyc %0d ch %0d n %0d", o/64, (o%64)/2, o%2, e/64, (e%64)/2, e%2);
            end
        end
        lk_hi = 0; quiet = 0;
        for (int c = 81; c <= 96; c++) begin
            if (lk_hist[c] !== 1'b0) lk_hi++;
            if (cp_hist[c] !== '0 || cn_hist[c] !== '0) quiet++;
        end
        n_cmp++; if (lk_hi != 0) begin n_bad++; $display("FAIL relock_low got %0d high cycles expected 0", lk_hi); end
        n_cmp++; if (quiet != 0) begin n_bad++; $display("FAIL relock_quiet got %0d pulse cycles expected 0", quiet); end
        n_cmp++; if (lk_hist[97] !== 1'b1) begin n_bad++; $display("FAIL relock_rise got %b at cycle 97 expected 1", lk_hist[97]); end
        first_p = -1; first_n = -1; np = 0; nn = 0;
        for (int c = 98; c <= 897; c++) begin
            if (cp_hist[c][1] === 1'b1) begin np++; if (first_p < 0) first_p = c; end
            if (cn_hist[c][1] === 1'b1) begin nn++; if (first_n < 0) first_n = c; end
        end
        n_cmp++; if (first_p != 100) begin n_bad++; $display("FAIL ch1_first_p got %0d expected 100", first_p); end
        n_cmp++; if (first_n != 99) begin n_bad++; $display("FAIL ch1_first_n got %0d expected 99", first_n); end
        n_cmp++; if (np != 300) begin n_bad++; $display("FAIL ch1_count_p got %0d expected 300", np); end
        n_cmp++; if (nn != 300) begin n_bad++; $display("FAIL ch1_count_n got %0d expected 300", nn); end
        bad_win = 0;
        for (int j = 0; j < 100; j++) begin
            w = 0;
            for (int c = 98 + 8*j; c <= 105 + 8*j; c++) if (cp_hist[c][1] === 1'b1) w++;
            if (w != 3) bad_win++;
        end
        n_cmp++; if (bad_win != 0) begin n_bad++; $display("FAIL ch1_windows got %0d bad windows expected 0", bad_win); end
        bad_rep = 0;
        for (int c = 106; c <= 897; c++)
            if (cp_hist[c][1] !== cp_hist[c-8][1] || cn_hist[c][1] !== cn_hist[c-8][1]) bad_rep++;
        n_cmp++; if (bad_rep != 0) begin n_bad++; $display("FAIL ch1_repeat got %0d differing cycles expected 0", bad_rep); end
    endtask

    task automatic test_pause();
        int e, o, tn, tp, lk_lo, quiet;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ch == 1) continue;
            for (int k = 0; k < 70; k++) begin
                tn = 105 + 16*k; tp = 113 + 16*k;
                if (tn >= 904) tn += 10;
                if (tp >= 904) tp += 10;
                if (tn >= 898 && tn <= 955) exp_q.push_back(tn*64 + ch*2 + 1);
                if (tp >= 898 && tp <= 955) exp_q.push_back(tp*64 + ch*2);
            end
        end
        exp_q.sort();
        collect(903 - cyc, 4'b1101);
        pause = 1'b1;
        collect(10, 4'b1101);
        pause = 1'b0;
        collect(955 - cyc, 4'b1101);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL pause_ev got cyc %0d ch %0d n %0d expected cyc %0d ch %0d n %0d", o/64, (o%64)/2, o%2, e/64, (e%64)/2, e%2);
            end
        end
        lk_lo = 0; quiet = 0;
        for (int c = 898; c <= 955; c++) if (lk_hist[c] !== 1'b1) lk_lo++;
        for (int c = 904; c <= 913; c++) if (cp_hist[c] !== '0 || cn_hist[c] !== '0) quiet++;
        n_cmp++; if (lk_lo != 0) begin n_bad++; $display("FAIL pause_locked got %0d low cycles expected 0", lk_lo); end
        n_cmp++; if (quiet != 0) begin n_bad++; $display("FAIL pause_quiet got %0d pulse cycles expected 0", quiet); end
    endtask

    task automatic test_ch_en();
        int e, o, tn, tp;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ch == 1) continue;
            for (int k = 0; k < 70; k++) begin
                tn = 105 + 16*k + 10; tp = 113 + 16*k + 10;
                if (tn >= 956 && tn <= 1005 && !(ch == 2 && tn > 960)) exp_q.push_back(tn*64 + ch*2 + 1);
                if (tp >= 956 && tp <= 1005 && !(ch == 2 && tp > 960)) exp_q.push_back(tp*64 + ch*2);
            end
        end
        for (int t = 965 + 8; t <= 1005; t += 16) begin
            exp_q.push_back(t*64 + 2*2 + 1);
            if (t + 8 <= 1005) exp_q.push_back((t + 8)*64 + 2*2);
        end
        exp_q.sort();
        collect(960 - cyc, 4'b1101);
        ch_en = 4'b1011;
        collect(5, 4'b1101);
        ch_en = 4'b1111;
        collect(1005 - cyc, 4'b1101);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL chen_ev got cyc %0d ch %0d n %0d expected cyc %0d ch %0d n %0d", o/64, (o%64)/2, o%2, e/64, (e%64)/2, e%2);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        int e, o, rise;
        wr = 1'b1; wr_ch = 2'd2; wr_inc = 24'h080000;
        collect(1, '1);
        wr = 1'b0; wr_inc = '0;
        collect(4, '1);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL settle_locked got %b expected 0", locked); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL settle_quiet got %0d pulses expected 0", obs_q.size()); end
        obs_q.delete();
        reset = 1'b1;
        collect(2, '0);
        reset = 1'b0;
        cyc = 0;
        obs_q.delete();
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int t = LOCK + 8; t + 8 <= 48; t += 16) begin
                exp_q.push_back(t*64 + ch*2 + 1);
                exp_q.push_back((t + 8)*64 + ch*2);
            end
        exp_q.sort();
        rise = -1;
        for (int i = 0; i < 40 && rise < 0; i++) begin
            collect(1, '1);
            if (locked === 1'b1) rise = cyc;
        end
        n_cmp++; if (rise != LOCK) begin n_bad++; $display("FAIL rst_lock_rise got cycle %0d expected %0d", rise, LOCK); end
        collect(48 - cyc, '1);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = -1; o = -1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rst_ev got cyc %0d ch %0d n %0d expected cyc %0d ch %0d n %0d", o/64, (o%64)/2, o%2, e/64, (e%64)/2, e%2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_write_relock();
        test_pause();
        test_ch_en();
        test_reset_mid_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
